// File: rtl/uart_pkg.sv
// uart_pkg: register map, MR/SR/CR bit positions and FSM state types shared by the UART channel.
package uart_pkg;
  localparam logic [1:0] ADDR_MR  = 2'd0;
  localparam logic [1:0] ADDR_SR  = 2'd1;
  localparam logic [1:0] ADDR_CR  = 2'd1;
  localparam logic [1:0] ADDR_DIV = 2'd2;
  localparam logic [1:0] ADDR_RHR = 2'd3;
  localparam logic [1:0] ADDR_THR = 2'd3;
  localparam int MR_PEN   = 2;
  localparam int MR_ODD   = 3;
  localparam int MR_STOP2 = 4;
  localparam int SR_RXRDY = 0;
  localparam int SR_FFULL = 1;
  localparam int SR_TXRDY = 2;
  localparam int SR_TXEMT = 3;
  localparam int SR_OVR   = 4;
  localparam int SR_PERR  = 5;
  localparam int SR_FERR  = 6;
  localparam int CR_RXEN  = 0;
  localparam int CR_TXEN  = 1;
  localparam int CR_RXIE  = 2;
  localparam int CR_TXIE  = 3;
  localparam int CR_CLR   = 4;
  localparam int CR_FLRX  = 5;
  localparam int CR_FLTX  = 6;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  // index of the last data bit for a 5..8 bit character length code
  function automatic logic [2:0] last_bit(input logic [1:0] len);
    return {1'b1, len};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; pop on empty is ignored, push on full only succeeds with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= din;
endmodule

// File: rtl/uart_channel.sv
// uart_channel: bus-mapped UART channel with RX/TX FIFOs, programmable 16x baud tick,
// framed transmitter and mid-bit sampling receiver.
module uart_channel
  import uart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = 8'h0B
) (
  input  logic       CLK,
  input  logic       _RESET,
  input  logic [1:0] A,
  input  logic       R_W,
  input  logic       CS,
  inout  wire  [7:0] DATA,
  input  logic       RX,
  output logic       TX,
  output logic       RxRDY,
  output logic       FFULL,
  output logic       TxRDY,
  output logic       _INT
);
  logic [4:0] mr;
  logic [3:0] cr, tcnt, rcnt;
  logic [7:0] div, bcnt, rd_data, sr, tx_dout, rx_dout, rx_din, tsh, rsh;
  logic [2:0] tbit, rbit;
  logic [1:0] rx_s;
  logic wr_done, rd_q, rd_rhr, ovr, perr, ferr, tpar, tstop, rpar;
  logic wr, clr, fl_rx, fl_tx, tick, tx_push, tx_pop, rx_pop, rx_done, rx_empty, tx_empty, tx_full;
  tx_state_t ts;
  rx_state_t rs;
  assign wr = CS & ~R_W & ~wr_done;
  assign clr = wr && A == ADDR_CR && DATA[CR_CLR];
  assign fl_rx = wr && A == ADDR_CR && DATA[CR_FLRX];
  assign fl_tx = wr && A == ADDR_CR && DATA[CR_FLTX];
  assign tick = bcnt == div;
  assign tx_push = wr && A == ADDR_THR;
  assign tx_pop = tick && ts == T_IDLE && cr[CR_TXEN] && !tx_empty;
  assign rx_pop = ~CS & rd_rhr;
  assign rx_done = tick && rs == R_STOP && rcnt == 4'hF;
  assign rx_din = rsh >> (2'd3 - mr[1:0]);
  assign RxRDY = ~rx_empty;
  assign TxRDY = ~tx_full;
  assign DATA = (CS & R_W & rd_q) ? rd_data : 8'hzz;
  always_comb begin
    sr = '0;
    sr[SR_RXRDY] = RxRDY;
    sr[SR_FFULL] = FFULL;
    sr[SR_TXRDY] = TxRDY;
    sr[SR_TXEMT] = tx_empty && ts == T_IDLE;
    sr[SR_OVR] = ovr;
    sr[SR_PERR] = perr;
    sr[SR_FERR] = ferr;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK), .rst_n(_RESET), .flush(fl_rx), .push(rx_done), .pop(rx_pop),
    .din(rx_din), .dout(rx_dout), .empty(rx_empty), .full(FFULL));
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK), .rst_n(_RESET), .flush(fl_tx), .push(tx_push), .pop(tx_pop),
    .din(DATA), .dout(tx_dout), .empty(tx_empty), .full(tx_full));
  // bus side: one write per CS assertion, registered read data, baud counter restarts on DIV writes
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      {wr_done, rd_q, rd_rhr} <= '0;
      rd_data <= '0;
      mr <= 5'h03;
      cr <= '0;
      div <= DIV_RESET;
      bcnt <= '0;
      _INT <= 1'b1;
    end else begin
      wr_done <= CS & (wr_done | wr);
      rd_q <= CS & R_W;
      rd_rhr <= CS & R_W & (A == ADDR_RHR);
      rd_data <= A == ADDR_MR ? {3'b000, mr} : A == ADDR_SR ? sr : A == ADDR_DIV ? div : (RxRDY ? rx_dout : 8'h00);
      if (wr && A == ADDR_MR) mr <= DATA[4:0];
      if (wr && A == ADDR_CR) cr <= DATA[3:0];
      if (wr && A == ADDR_DIV) div <= DATA;
      bcnt <= (tick || (wr && A == ADDR_DIV)) ? 8'h00 : bcnt + 8'd1;
      _INT <= !((RxRDY & cr[CR_RXIE]) | (TxRDY & cr[CR_TXIE]));
    end
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      ts <= T_IDLE;
      {tcnt, tbit, tsh, tpar, tstop} <= '0;
      TX <= 1'b1;
    end else if (tick) begin
      if (ts == T_IDLE) begin
        if (tx_pop) begin
          ts <= T_START;
          TX <= 1'b0;
          tsh <= tx_dout;
          tpar <= mr[MR_ODD];
          {tcnt, tbit, tstop} <= '0;
        end
      end else begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'hF)
          case (ts)
            T_START: begin
              ts <= T_DATA;
              TX <= tsh[0];
              tpar <= tpar ^ tsh[0];
              tsh <= tsh >> 1;
            end
            T_DATA:
              if (tbit == last_bit(mr[1:0])) begin
                ts <= mr[MR_PEN] ? T_PARITY : T_STOP;
                TX <= mr[MR_PEN] ? tpar : 1'b1;
              end else begin
                tbit <= tbit + 3'd1;
                TX <= tsh[0];
                tpar <= tpar ^ tsh[0];
                tsh <= tsh >> 1;
              end
            T_PARITY: begin
              ts <= T_STOP;
              TX <= 1'b1;
            end
            default:
              if (mr[MR_STOP2] && !tstop) tstop <= 1'b1;
              else ts <= T_IDLE;
          endcase
      end
    end
  // receiver: start confirmed at tick 8, then every 16th tick lands mid-bit
  always_ff @(posedge CLK or negedge _RESET)
    if (!_RESET) begin
      rs <= R_IDLE;
      {rcnt, rbit, rsh, rpar, ovr, perr, ferr} <= '0;
      rx_s <= 2'b11;
    end else begin
      rx_s <= {rx_s[0], RX};
      ovr <= (ovr & ~clr) | (rx_done & FFULL & ~(rx_pop & RxRDY) & ~fl_rx);
      perr <= (perr & ~clr) | (tick && rs == R_PARITY && rcnt == 4'hF && (rpar ^ rx_s[1]) != mr[MR_ODD]);
      ferr <= (ferr & ~clr) | (rx_done & ~rx_s[1]);
      if (tick) begin
        if (rs == R_IDLE) begin
          if (cr[CR_RXEN] && !rx_s[1]) begin
            rs <= R_START;
            {rcnt, rbit, rsh, rpar} <= '0;
          end
        end else begin
          rcnt <= rcnt + 4'd1;
          if (rs == R_START && rcnt == 4'd7) begin
            rs <= rx_s[1] ? R_IDLE : R_DATA;
            rcnt <= '0;
          end else if (rcnt == 4'hF)
            case (rs)
              R_DATA: begin
                rsh <= {rx_s[1], rsh[7:1]};
                rpar <= rpar ^ rx_s[1];
                rbit <= rbit + 3'd1;
                if (rbit == last_bit(mr[1:0])) rs <= mr[MR_PEN] ? R_PARITY : R_STOP;
              end
              R_PARITY: rs <= R_STOP;
              default: rs <= R_IDLE;
            endcase
        end
      end
    end
endmodule

// File: doc/uart_channel.md
UART_CHANNEL -- requirements
Module: uart_channel

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: RX and TX FIFO depth each; power of two, >= 2.
REQ-002 SHALL have parameter DIV_RESET, default 8'h0B: baud divisor reset value.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port _RESET, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port A, input, 2: register select.
REQ-006 SHALL have port R_W, input, 1: 1 = read, 0 = write.
REQ-007 SHALL have port CS, input, 1: active-high channel select, decoded upstream.
REQ-008 SHALL have port DATA, inout, 8: bus; driven only while CS=1 and R_W=1, otherwise high-Z.
REQ-009 SHALL have port RX, input, 1: serial in, asynchronous.
REQ-010 SHALL have port TX, output, 1: serial out, idle high.
REQ-011 SHALL have ports RxRDY, FFULL, TxRDY, output, 1 each: RX FIFO non-empty, RX FIFO full, TX FIFO not full.
REQ-012 SHALL have port _INT, output, 1: active-low interrupt.

Function
REQ-013 SHALL decode A as: 0 = MR (R/W), 1 = SR read / CR write, 2 = DIV (R/W), 3 = RHR read / THR write.
REQ-014 SHALL define MR as: [1:0] char length 5..8 bits; [2] parity enable; [3] odd parity; [4] two stop bits; [7:5] read as 0.
REQ-015 SHALL define SR as: [0] RxRDY; [1] FFULL; [2] TxRDY; [3] TxEMT (TX FIFO empty and shifter idle); [4] overrun; [5] parity error; [6] framing error; [7] 0.
REQ-016 SHALL treat CR bits as: [0] RX enable; [1] TX enable; [2] RX interrupt enable; [3] TX interrupt enable (all level bits); [4] clear SR[6:4]; [5] flush RX FIFO; [6] flush TX FIFO ([6:4] write-1 self-clearing).
REQ-017 SHALL perform a register write once per access, on the first CLK edge with CS=1 and R_W=0 after CS was 0.
REQ-018 SHALL drive DATA with the read value one CLK after CS=1 and R_W=1.
REQ-019 SHALL pop RHR on the CLK edge where CS falls, if the access was a read at A=3.
REQ-020 SHALL return 8'h00 and not pop when RHR is read while the RX FIFO is empty.
REQ-021 SHALL ignore a THR write while the TX FIFO is full; no flag is set.
REQ-022 SHALL produce a 16x tick every DIV+1 CLKs; one bit time = 16 ticks.
REQ-023 SHALL give the TX FSM the states IDLE, START, DATA, PARITY, STOP; the shift order is LSB first.
REQ-024 SHALL start a character (IDLE->START) on the first tick with TX enabled and the TX FIFO non-empty.
REQ-025 SHALL, when TX is disabled mid-character, finish the current character, then hold IDLE.
REQ-026 SHALL double-flop RX before use.
REQ-027 SHALL detect a start bit on a low level seen on a tick while idle.
REQ-028 SHALL re-check the start bit at tick 8; if RX is high, SHALL return to idle (glitch rejected).
REQ-029 SHALL sample each subsequent bit at mid-bit, i.e. every 16 ticks.
REQ-030 SHALL set SR[6] when the first stop bit samples 0, and SR[5] on a parity mismatch.
REQ-031 SHALL push the character (MSBs zero-filled) when it completes; if the RX FIFO is full, SHALL discard it and set SR[4].
REQ-032 SHALL allow push and pop in the same CLK on a full FIFO: both occur and the count is unchanged.
REQ-033 SHALL, on a same-CLK push and pop on an empty FIFO, perform the push only.
REQ-034 SHALL let the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-035 SHALL drive _INT = !((RxRDY & CR[2]) | (TxRDY & CR[3])), registered.
REQ-036 SHALL give the CR[5] and CR[6] flushes priority over a same-cycle push.

Reset
REQ-037 SHALL set, while _RESET=0: TX=1, _INT=1, DATA high-Z, MR=8'h03, DIV=DIV_RESET, CR=0, SR flags=0, FIFOs empty, FSMs IDLE.
REQ-038 SHALL abort any character in progress on reset, with no partial push.

Structure
REQ-039 SHALL place in shared package uart_pkg: register address constants, MR/SR/CR bit indices, TX/RX state typedefs.
REQ-040 SHALL implement the FIFOs as sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice.

Verification
REQ-041 SHALL cover: DIV=0, MR=8'h03, CR=8'h03, write THR 8'hA5 -> TX frame 0,1,0,1,0,0,1,0,1,1, each bit 16 CLKs.
REQ-042 SHALL cover: FIFO_DEPTH=4, RX enabled, 5 chars received without reads -> FFULL=1, SR[4]=1, first 4 chars read back in order.
REQ-043 SHALL cover: MR=8'h0F (8O1), RX 8'h01 sent with even parity -> SR[5]=1; CR write 8'h10 -> SR[5]=0.
REQ-044 SHALL cover: a 4-CLK low glitch on RX with DIV=0 -> no character, RxRDY stays 0.
REQ-045 SHALL cover: CR=8'h0E, TX FIFO filled with 4 writes -> TxRDY=0, _INT=1; the first character starts -> TxRDY=1, _INT=0.
REQ-046 SHALL cover: _RESET asserted mid-TX-data-bit -> TX=1 immediately, TxEMT=1 after release.
